// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage RV32 pipeline: load-use stalls,
// redirect flushes, data-memory waits, debug halt/drain/resume, perf counters.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             redirect_valid,
    input  logic             dmem_busy,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          halt_pend, halt_pend_nxt;
    logic          stall_inc, flush_inc;
    logic          load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            halt_pend <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            halt_pend <= halt_pend_nxt;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        halt_pend_nxt = halt_pend;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        halted        = 1'b0;

        unique case (state)
            RUN: begin
                if (dmem_busy) begin
                    // Redirect stays held by the frozen MEM stage; it is taken later.
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                    stall_inc = 1'b1;
                end else if (redirect_valid) begin
                    {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end

                if (halt_pend && !dmem_busy) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_INIT;
                    halt_pend_nxt = 1'b0;
                end else if (halt_req) begin
                    halt_pend_nxt = 1'b1;
                end
            end

            DRAIN: begin
                if (dmem_busy) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                end else begin
                    if (redirect_valid) begin
                        // Capture the redirect target so resume restarts at it.
                        {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
                        flush_inc = 1'b1;
                    end else begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                    if (drain_cnt == '0)
                        state_nxt = HALTED;
                    else
                        drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end

            HALTED: begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                halted = 1'b1;
                if (resume_req)
                    state_nxt = RUN;
            end

            default: state_nxt = RUN;
        endcase

        if (rst) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
            {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b000;
            halted = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic             redirect_valid, dmem_busy, halt_req, resume_req;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: mode 0=running, 1=draining, 2=halted
    int m_mode, m_left, m_stall, m_flush;
    bit m_pend;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .redirect_valid(redirect_valid), .dmem_busy(dmem_busy),
        .halt_req(halt_req), .resume_req(resume_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctl_obs();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, halted};
    endfunction

    task automatic mreset();
        m_mode = 0; m_left = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic bit hazard();
        if (!ex_mem_read || ex_rd == 0) return 0;
        return (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
    endfunction

    // Expected control vector {pc,ifid,idex,exmem,memwb,f_ifid,f_idex,f_exmem,halted}
    task automatic model_out(output logic [8:0] e, output bit si, output bit fi);
        si = 0; fi = 0;
        if (rst)                      e = 9'b11111_000_0;
        else if (m_mode == 2)         e = 9'b00000_000_1;
        else if (dmem_busy) begin     e = 9'b00000_000_0; si = (m_mode == 0); end
        else if (redirect_valid) begin e = 9'b11111_111_0; fi = 1; end
        else if (m_mode == 1)         e = 9'b01111_100_0;
        else if (hazard()) begin      e = 9'b00111_010_0; si = 1; end
        else                          e = 9'b11111_000_0;
    endtask

    task automatic model_next(input bit si, input bit fi);
        if (si && m_stall < CNT_MAX) m_stall++;
        if (fi && m_flush < CNT_MAX) m_flush++;
        case (m_mode)
            0: begin
                if (m_pend && !dmem_busy) begin
                    m_mode = 1; m_left = DRAIN_CYCLES; m_pend = 0;
                end else if (halt_req) m_pend = 1;
            end
            1: if (!dmem_busy) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
            default: if (resume_req) m_mode = 0;
        endcase
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic [8:0] e;
        bit si, fi;
        @(negedge clk);
        if (rst) mreset();
        model_out(e, si, fi);
        chk("ctl", {23'd0, ctl_obs()}, {23'd0, e});
        chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
        chk("flush_cnt", {28'd0, flush_cnt}, m_flush);
        @(posedge clk);
        if (!rst) model_next(si, fi);
        #1;
    endtask

    task automatic idle_in();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; redirect_valid = 0; dmem_busy = 0;
        halt_req = 0; resume_req = 0;
    endtask

    task automatic load_use_in(input logic [4:0] rd);
        ex_mem_read = 1; ex_rd = rd; id_rs2 = 5; id_uses_rs2 = 1;
    endtask

    initial begin
        mreset();
        idle_in();
        rst = 1;
        #1;
        step();
        chk("reset_pc_en", {31'd0, pc_en}, 32'd1);
        rst = 0;
        step();

        // load-use: single bubble, then rd=0 never stalls
        load_use_in(5); step();
        idle_in(); step();
        chk("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);
        load_use_in(0); step();
        idle_in(); step();

        // redirect beats a simultaneous load-use
        load_use_in(5); redirect_valid = 1; step();
        idle_in(); step();
        chk("redir_flush_cnt", {28'd0, flush_cnt}, 32'd1);

        // dmem wait with redirect held, redirect taken on the fourth cycle
        redirect_valid = 1; dmem_busy = 1;
        repeat (3) step();
        dmem_busy = 0; step();
        idle_in(); step();
        chk("busy_stall_cnt", {28'd0, stall_cnt}, 32'd4);

        // halt, drain, resume
        halt_req = 1; step();
        idle_in();
        repeat (1 + DRAIN_CYCLES + 2) step();
        chk("halted_flag", {31'd0, halted}, 32'd1);
        halt_req = 1; step();
        idle_in(); resume_req = 1; step();
        resume_req = 0; step();

        // halt with redirect in drain cycle 2 and busy in drain cycle 3
        halt_req = 1; step();
        idle_in(); step();
        step();
        redirect_valid = 1; step();
        redirect_valid = 0; dmem_busy = 1; step();
        dmem_busy = 0;
        repeat (4) step();
        resume_req = 1; step();
        resume_req = 0; step();

        // saturation, then reset from HALTED
        dmem_busy = 1;
        repeat (20) step();
        dmem_busy = 0; step();
        chk("sat_stall_cnt", {28'd0, stall_cnt}, CNT_MAX);
        halt_req = 1; step();
        halt_req = 0;
        repeat (1 + DRAIN_CYCLES) step();
        @(negedge clk); #2;
        rst = 1; #1;
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
        @(posedge clk); #1;
        step();
        rst = 0; step();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(99) < 2);
            dmem_busy      = ($urandom_range(99) < 20);
            redirect_valid = ($urandom_range(99) < 15);
            ex_mem_read    = ($urandom_range(1) == 1);
            ex_rd          = 5'($urandom_range(3));
            id_rs1         = 5'($urandom_range(3));
            id_rs2         = 5'($urandom_range(3));
            id_uses_rs1    = ($urandom_range(1) == 1);
            id_uses_rs2    = ($urandom_range(1) == 1);
            halt_req       = ($urandom_range(99) < 6);
            resume_req     = ($urandom_range(99) < 12);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Drives the PC enable and the IF_ID, ID_EX, EX_MEM and MEM_WB enables, plus per-register flush (bubble insert) strobes.
- Handles load-use stalls, redirect flushes from taken branch/JAL/JALR, multi-cycle data-memory waits, and a debug halt/drain/resume sequence.
- Keeps saturating stall and flush counters for performance bring-up.

Parameters:
- DRAIN_CYCLES, 4, cycles spent draining in-flight instructions after a halt before HALTED is reached (must be ≥1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  the ID instruction reads rs1.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- redirect_valid  in  1  taken branch/JAL/JALR resolved in MEM; PC target valid this cycle.
- dmem_busy  in  1  data memory has not completed this cycle.
- halt_req  in  1  single-cycle halt request pulse.
- resume_req  in  1  single-cycle resume request pulse.
- pc_en  out  1  PC register load enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a NOP bubble (all control bits 0) at the next edge.
- halted  out  1  core fully drained and frozen.
- stall_cnt  out  CNT_W  number of stall cycles.
- flush_cnt  out  CNT_W  number of redirects accepted.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. The state, drain counter, halt_pend flag and counters are registered. All other outputs are combinational from state and inputs.
- Reset (rst=1, async):
  - State goes to RUN; drain counter, halt_pend, stall_cnt and flush_cnt go to 0.
  - While rst=1, all enables are 1, all flushes are 0, and halted is 0.
- Load-use hazard definition: ex_mem_read && ex_rd≠0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- RUN priority, highest first:
  1. dmem_busy: all five enables 0, no flushes; redirect is ignored and must stay asserted by the frozen MEM stage; stall_cnt+1.
  2. redirect_valid: all enables 1; if_id_flush, id_ex_flush and ex_mem_flush are 1; flush_cnt+1. Load-use is suppressed, because the dependent instruction is squashed.
  3. load-use: pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1; stall_cnt+1. This yields exactly one bubble per hazard.
  4. otherwise: all enables 1, no flushes.
- Halt entry:
  - halt_req in RUN sets halt_pend.
  - At the first RUN cycle with halt_pend=1 and dmem_busy=0, the FSM moves to DRAIN with the counter at DRAIN_CYCLES-1 and clears halt_pend.
  - halt_req arriving in the same cycle as a stall or redirect is not lost; the transition happens after the redirect cycle.
- DRAIN:
  - pc_en=0, if_id_flush=1, other enables 1.
  - dmem_busy freezes all enables and the counter.
  - redirect_valid forces pc_en=1 and asserts all three flushes so the target is captured; the counter keeps running. flush_cnt+1.
  - Load-use is ignored.
  - When the counter is 0 and not busy, go to HALTED.
- HALTED:
  - All enables 0, no flushes, halted=1.
  - halt_req is ignored.
  - resume_req causes RUN next cycle; halted drops in that same cycle.
  - resume_req outside HALTED is ignored.
- Counters saturate at 2^CNT_W-1. Drain and HALTED cycles do not count as stalls.
- A mid-operation reset abandons DRAIN/HALTED immediately and returns to RUN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Redirect with a simultaneous load-use -> all enables 1; if_id/id_ex/ex_mem_flush=1 for 1 cycle; flush_cnt=1; stall_cnt unchanged.
- dmem_busy for 3 cycles with redirect_valid held -> all enables 0 for 3 cycles, stall_cnt=3; redirect flush occurs on the 4th cycle only.
- halt_req pulse in RUN -> DRAIN for 4 cycles (pc_en=0, if_id_flush=1), then halted=1 with all enables 0; resume_req -> RUN and pc_en=1 next cycle.
- Halt during drain: redirect in DRAIN cycle 2 plus dmem_busy in cycle 3 -> pc_en=1 on the redirect cycle; drain extends by 1 cycle; HALTED reached after 5 cycles.
- Saturation/reset: with CNT_W=4, apply 20 stall cycles -> stall_cnt=15. Assert rst in HALTED -> immediate RUN, counters 0, halted=0.
